// File: rtl/wishbone_slave_pkg.sv
// rtl/wishbone_slave_pkg.sv - shared state encodings, response codes and memory-map defaults
package wishbone_slave_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_RESP = 2'd2
    } wb_state_t;

    typedef enum logic {
        WB_RSP_OK  = 1'b0,
        WB_RSP_ERR = 1'b1
    } wb_rsp_t;

    localparam logic [31:0] WB_DEFAULT_BASE = 32'h0000_0000;
    localparam logic [31:0] WB_DEFAULT_MASK = 32'hFFFF_0000;

    // Width needed to count 0..timeout; never zero so a disabled timeout still elaborates.
    function automatic int wb_ctr_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wishbone_timeout_ctr.sv
// rtl/wishbone_timeout_ctr.sv - saturating wait counter that flags the last allowed REQ cycle
module wishbone_timeout_ctr
    import wishbone_slave_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_CLR,
    input  logic i_EN,
    output logic o_EXPIRED
);

    localparam int W = wb_ctr_width(TIMEOUT);
    localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);
    localparam logic [W-1:0] SAT  = W'(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST || i_CLR) begin
            r_cnt <= '0;
        end else if (i_EN && (TIMEOUT != 0) && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry lands on the edge that closes the TIMEOUT-th strobe cycle.
    assign o_EXPIRED = (TIMEOUT != 0) && i_EN && (r_cnt == LAST);

endmodule

// File: rtl/wishbone_slave.sv
// rtl/wishbone_slave.sv - Wishbone B4 classic-cycle target bridging to a held-strobe device port
module wishbone_slave
    import wishbone_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(WB_DEFAULT_BASE),
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'(WB_DEFAULT_MASK),
    parameter int                    TIMEOUT    = 15
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_CYC,
    input  logic                      i_STB,
    input  logic                      i_WE,
    input  logic [ADDR_WIDTH-1:0]     i_ADDR,
    input  logic [DATA_WIDTH-1:0]     i_DATA,
    input  logic [DATA_WIDTH/8-1:0]   i_SEL,
    input  logic                      i_TAGN,
    output logic [DATA_WIDTH-1:0]     o_DATA,
    output logic                      o_ACK,
    output logic                      o_ERR,
    output logic                      o_TAGN,
    output logic [ADDR_WIDTH-1:0]     o_DEV_ADDR,
    output logic [DATA_WIDTH-1:0]     o_DEV_WDATA,
    output logic [DATA_WIDTH/8-1:0]   o_DEV_BE,
    output logic                      o_DEV_WE,
    output logic                      o_DEV_RE,
    input  logic [DATA_WIDTH-1:0]     i_DEV_RDATA,
    input  logic                      i_DEV_RDY
);

    localparam int SEL_W = DATA_WIDTH / 8;

    wb_state_t               r_state;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_ack;
    logic                    r_err;
    logic                    r_tagn;
    logic [ADDR_WIDTH-1:0]   r_dev_addr;
    logic [DATA_WIDTH-1:0]   r_dev_wdata;
    logic [SEL_W-1:0]        r_dev_be;
    logic                    r_dev_we;
    logic                    r_dev_re;

    logic w_hit;
    logic w_in_req;
    logic w_expired;

    assign w_hit    = ((i_ADDR & ADDR_MASK) == BASE_ADDR);
    assign w_in_req = (r_state == WB_REQ);

    wishbone_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_CLR     (!w_in_req),
        .i_EN      (w_in_req),
        .o_EXPIRED (w_expired)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state     <= WB_IDLE;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_tagn      <= 1'b0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_dev_be    <= '0;
            r_dev_we    <= 1'b0;
            r_dev_re    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (i_CYC && i_STB) begin
                        r_dev_addr  <= i_ADDR & ~ADDR_MASK;
                        r_dev_wdata <= i_DATA;
                        r_dev_be    <= i_SEL;
                        r_tagn      <= i_TAGN;
                        if (w_hit) begin
                            r_state  <= WB_REQ;
                            r_dev_we <= i_WE;
                            r_dev_re <= !i_WE;
                        end else begin
                            r_state <= WB_RESP;
                            r_err   <= 1'b1;
                        end
                    end
                end
                WB_REQ: begin
                    // Ready wins over expiry when both land on the same cycle.
                    if (!i_CYC) begin
                        r_state  <= WB_IDLE;
                        r_dev_we <= 1'b0;
                        r_dev_re <= 1'b0;
                    end else if (i_DEV_RDY) begin
                        if (r_dev_re) begin
                            r_data <= i_DEV_RDATA;
                        end
                        r_state  <= WB_RESP;
                        r_ack    <= 1'b1;
                        r_dev_we <= 1'b0;
                        r_dev_re <= 1'b0;
                    end else if (w_expired) begin
                        r_state  <= WB_RESP;
                        r_err    <= 1'b1;
                        r_dev_we <= 1'b0;
                        r_dev_re <= 1'b0;
                    end
                end
                WB_RESP: begin
                    r_state <= WB_IDLE;
                end
                default: begin
                    r_state <= WB_IDLE;
                end
            endcase
        end
    end

    assign o_DATA      = r_data;
    assign o_ACK       = r_ack;
    assign o_ERR       = r_err;
    assign o_TAGN      = r_tagn;
    assign o_DEV_ADDR  = r_dev_addr;
    assign o_DEV_WDATA = r_dev_wdata;
    assign o_DEV_BE    = r_dev_be;
    assign o_DEV_WE    = r_dev_we;
    assign o_DEV_RE    = r_dev_re;

endmodule

// File: tb/tb_wishbone_slave.sv
// tb/tb_wishbone_slave.sv - randomized master/device bench with a transaction-level response model
module tb_wishbone_slave;

    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_CYC;
    logic        i_STB;
    logic        i_WE;
    logic [31:0] i_ADDR;
    logic [31:0] i_DATA;
    logic [3:0]  i_SEL;
    logic        i_TAGN;
    logic [31:0] o_DATA;
    logic        o_ACK;
    logic        o_ERR;
    logic        o_TAGN;
    logic [31:0] o_DEV_ADDR;
    logic [31:0] o_DEV_WDATA;
    logic [3:0]  o_DEV_BE;
    logic        o_DEV_WE;
    logic        o_DEV_RE;
    logic [31:0] i_DEV_RDATA;
    logic        i_DEV_RDY;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_data;

    always #5 i_CLK = ~i_CLK;

    wishbone_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .ADDR_MASK  (MASK),
        .TIMEOUT    (TO)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_CYC       (i_CYC),
        .i_STB       (i_STB),
        .i_WE        (i_WE),
        .i_ADDR      (i_ADDR),
        .i_DATA      (i_DATA),
        .i_SEL       (i_SEL),
        .i_TAGN      (i_TAGN),
        .o_DATA      (o_DATA),
        .o_ACK       (o_ACK),
        .o_ERR       (o_ERR),
        .o_TAGN      (o_TAGN),
        .o_DEV_ADDR  (o_DEV_ADDR),
        .o_DEV_WDATA (o_DEV_WDATA),
        .o_DEV_BE    (o_DEV_BE),
        .o_DEV_WE    (o_DEV_WE),
        .o_DEV_RE    (o_DEV_RE),
        .i_DEV_RDATA (i_DEV_RDATA),
        .i_DEV_RDY   (i_DEV_RDY)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // One master transaction against a device that raises RDY on its (waits+1)-th strobe cycle.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input logic tag, input int waits,
                           input logic [31:0] rdata, input bit last);
        bit hit;
        int exp_strobe;
        int exp_resp_c;
        bit exp_err;
        int strobe_n;
        int resp_c;
        bit got_err;
        hit      = ((addr & MASK) == BASE);
        strobe_n = 0;
        resp_c   = 0;
        got_err  = 0;
        if (!hit) begin
            exp_strobe = 0; exp_resp_c = 1; exp_err = 1;
        end else if (TO != 0 && waits + 1 > TO) begin
            exp_strobe = TO; exp_resp_c = TO + 1; exp_err = 1;
        end else begin
            exp_strobe = waits + 1; exp_resp_c = waits + 2; exp_err = 0;
        end
        i_CYC = 1; i_STB = 1; i_WE = we; i_ADDR = addr; i_DATA = wdata;
        i_SEL = sel; i_TAGN = tag; i_DEV_RDATA = rdata; i_DEV_RDY = 0;
        for (int c = 1; c <= 40 && resp_c == 0; c++) begin
            tick();
            i_DEV_RDY = 0;
            if (o_DEV_WE || o_DEV_RE) begin
                strobe_n++;
                check_eq("strobe_dir", {o_DEV_WE, o_DEV_RE}, we ? 2'b10 : 2'b01);
                check_eq("dev_addr", o_DEV_ADDR, addr & ~MASK);
                check_eq("dev_be", o_DEV_BE, sel);
                if (we) check_eq("dev_wdata", o_DEV_WDATA, wdata);
                if (strobe_n == waits + 1) i_DEV_RDY = 1;
            end
            if (o_ACK || o_ERR) begin
                resp_c  = c;
                got_err = o_ERR;
                check_eq("one_of_ack_err", o_ACK ^ o_ERR, 1'b1);
                check_eq("tagn", o_TAGN, tag);
            end
        end
        if (!exp_err && !we) m_data = rdata;
        check_eq("resp_latency", resp_c, exp_resp_c);
        check_eq("resp_is_err", got_err, exp_err);
        check_eq("strobe_cycles", strobe_n, exp_strobe);
        check_eq("rdata_hold", o_DATA, m_data);
        i_DEV_RDY = 0;
        if (last) begin
            i_CYC = 0;
            i_STB = 0;
        end
        tick();
        check_eq("no_dup_resp", {o_ACK, o_ERR, o_DEV_WE, o_DEV_RE}, 4'b0000);
    endtask

    initial begin
        i_RST = 1; i_CYC = 0; i_STB = 0; i_WE = 0; i_ADDR = '0; i_DATA = '0;
        i_SEL = '0; i_TAGN = 0; i_DEV_RDATA = '0; i_DEV_RDY = 0;
        m_data = '0;
        tick();
        tick();
        check_eq("reset_outs", {o_DATA, o_ACK, o_ERR, o_TAGN, o_DEV_WE, o_DEV_RE, o_DEV_BE}, '0);
        check_eq("reset_dev", {o_DEV_ADDR, o_DEV_WDATA}, '0);
        i_RST = 0;
        tick();

        do_xfer(0, 32'h0000_0010, 32'h0, 4'hF, 1, 0, 32'hDEAD_BEEF, 1);
        do_xfer(1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 0, 3, 32'h5555_AAAA, 1);
        do_xfer(0, 32'h0001_0000, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D, 1);
        do_xfer(0, 32'h0000_0040, 32'h0, 4'hF, 0, 10, 32'h0BAD_0BAD, 1);
        do_xfer(0, 32'h0000_0044, 32'h0, 4'hF, 1, 1, 32'h1111_2222, 1);
        do_xfer(1, 32'h0000_0048, 32'hA5A5_A5A5, 4'b0000, 0, 0, 32'h0, 1);

        // Abort: withdraw CYC mid-REQ while the device stays busy.
        i_CYC = 1; i_STB = 1; i_WE = 0; i_ADDR = 32'h0000_0080; i_TAGN = 1; i_DEV_RDY = 0;
        tick();
        tick();
        check_eq("abort_strobe_on", o_DEV_RE, 1'b1);
        i_CYC = 0; i_STB = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("abort_quiet", {o_ACK, o_ERR, o_DEV_WE, o_DEV_RE}, 4'b0000);
        end

        // Reset asserted while the ACK is on the bus.
        i_CYC = 1; i_STB = 1; i_WE = 0; i_ADDR = 32'h0000_0090; i_TAGN = 1;
        i_DEV_RDATA = 32'h7777_8888;
        tick();
        i_DEV_RDY = 1;
        tick();
        i_DEV_RDY = 0;
        check_eq("pre_reset_ack", o_ACK, 1'b1);
        i_RST = 1;
        tick();
        check_eq("mid_reset_outs", {o_DATA, o_ACK, o_ERR, o_TAGN, o_DEV_WE, o_DEV_RE, o_DEV_BE}, '0);
        m_data = '0;
        i_RST = 0; i_CYC = 0; i_STB = 0;
        tick();

        do_xfer(0, 32'h0000_0100, 32'h0, 4'hF, 1, 0, 32'h0102_0304, 0);
        do_xfer(0, 32'h0000_0104, 32'h0, 4'hF, 0, 0, 32'h0506_0708, 1);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            else addr = $urandom & 32'h0000_FFFF;
            do_xfer(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom,
                    bit'($urandom_range(0, 1)));
        end
        i_CYC = 0; i_STB = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
